// File: rtl/window_gen.sv
// Raster-order line buffer and KERNEL_W x KERNEL_W window generator feeding the conv stage.
// Emits only fully populated windows, one clock after the pixel that completes each one.
module window_gen #(
  parameter int DATA_W   = 8,
  parameter int KERNEL_W = 3,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480
) (
  input  logic                                         clk_i,
  input  logic                                         srst_i,
  input  logic [DATA_W-1:0]                            pixel_i,
  input  logic                                         pixel_valid_i,
  input  logic                                         sop_i,
  output logic [KERNEL_W-1:0][KERNEL_W-1:0][DATA_W-1:0] window_o,
  output logic                                         window_valid_o,
  output logic                                         eof_o,
  output logic                                         sop_err_o
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(KERNEL_W - 1);
  localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(KERNEL_W - 1);

  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] pos_col;
  logic [ROW_W-1:0] pos_row;
  logic             accept;
  logic             sop_hit;
  logic             emit;
  logic             at_last;

  assign accept  = pixel_valid_i && !srst_i;
  assign sop_hit = pixel_valid_i && sop_i;

  // A start-of-frame forces the current pixel to (0,0) regardless of the counters.
  assign pos_col = sop_hit ? '0 : col_reg;
  assign pos_row = sop_hit ? '0 : row_reg;
  assign emit    = (pos_row >= ROW_WIN) && (pos_col >= COL_WIN);
  assign at_last = (pos_col == COL_LAST) && (pos_row == ROW_LAST);

  logic [DATA_W-1:0]                 buf_rd [KERNEL_W-1];
  logic [KERNEL_W-1:0][DATA_W-1:0]   new_col;

  assign new_col[KERNEL_W-1] = pixel_i;

  // Read data must feed the window in the same cycle, so the line memories use asynchronous read.
  genvar gi;
  generate
    for (gi = 0; gi < KERNEL_W - 1; gi++) begin : g_line
      logic [DATA_W-1:0] line_mem [IMG_W];
      logic [DATA_W-1:0] wr_data;

      if (gi == 0) begin : g_head
        assign wr_data = pixel_i;
      end else begin : g_tail
        assign wr_data = buf_rd[gi-1];
      end

      assign buf_rd[gi]               = line_mem[pos_col];
      assign new_col[KERNEL_W-2-gi]   = buf_rd[gi];

      always_ff @(posedge clk_i) begin
        if (accept) begin
          line_mem[pos_col] <= wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int r = 0; r < KERNEL_W; r++) begin
        for (int c = 0; c < KERNEL_W - 1; c++) begin
          window_o[r][c] <= window_o[r][c+1];
        end
        window_o[r][KERNEL_W-1] <= new_col[r];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      col_reg        <= '0;
      row_reg        <= '0;
      window_valid_o <= 1'b0;
      eof_o          <= 1'b0;
      sop_err_o      <= 1'b0;
    end else begin
      window_valid_o <= 1'b0;
      eof_o          <= 1'b0;
      sop_err_o      <= 1'b0;
      if (pixel_valid_i) begin
        window_valid_o <= emit;
        eof_o          <= emit && at_last;
        sop_err_o      <= sop_i && ((col_reg != '0) || (row_reg != '0));
        if (pos_col == COL_LAST) begin
          col_reg <= '0;
          row_reg <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
        end else begin
          col_reg <= pos_col + 1'b1;
          row_reg <= pos_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen: image-based reference model feeding a window scoreboard,
// plus a table of fixed spot values checked against the captured windows.
module tb_window_gen;

  typedef logic [199:0] win_t;   // 5x5 bytes, index (r*5+c)

  typedef struct {
    int         test;
    int         id;
    int         widx;
    int         r;
    int         c;
    logic [7:0] val;
    bit         is_eof;
  } spot_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: KERNEL_W=3, 5x4 image
  logic                    srst3, pv3, sop3;
  logic [7:0]              px3;
  logic [2:0][2:0][7:0]    win3;
  logic                    wv3, eof3, err3;
  // DUT 1: KERNEL_W=5, 8x6 image
  logic                    srst5, pv5, sop5;
  logic [7:0]              px5;
  logic [4:0][4:0][7:0]    win5;
  logic                    wv5, eof5, err5;

  window_gen #(.DATA_W(8), .KERNEL_W(3), .IMG_W(5), .IMG_H(4)) dut3 (
    .clk_i(clk), .srst_i(srst3), .pixel_i(px3), .pixel_valid_i(pv3), .sop_i(sop3),
    .window_o(win3), .window_valid_o(wv3), .eof_o(eof3), .sop_err_o(err3));

  window_gen #(.DATA_W(8), .KERNEL_W(5), .IMG_W(8), .IMG_H(6)) dut5 (
    .clk_i(clk), .srst_i(srst5), .pixel_i(px5), .pixel_valid_i(pv5), .sop_i(sop5),
    .window_o(win5), .window_valid_o(wv5), .eof_o(eof5), .sop_err_o(err5));

  win_t flat3, flat5;
  always_comb begin
    flat3 = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        flat3[(r*5+c)*8 +: 8] = win3[r][c];
  end
  always_comb begin
    flat5 = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        flat5[(r*5+c)*8 +: 8] = win5[r][c];
  end

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  int KP[2] = '{3, 5};
  int WP[2] = '{5, 8};
  int HP[2] = '{4, 6};

  // Reference model state
  int         mcol[2];
  int         mrow[2];
  logic [7:0] img [2][8][8];
  win_t       q0[$];
  win_t       q1[$];
  logic [2:0] exp_next[2];   // {valid, eof, sop_err} expected after the coming edge
  logic [2:0] exp_cur[2];
  bit         acc_last[2];

  win_t cap_win[2][16];
  bit   cap_eof[2][16];
  int   wcount[2];
  int   err_seen[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      exp_next[i] = 3'b000; exp_cur[i] = 3'b000; acc_last[i] = 0;
      mcol[i] = 0; mrow[i] = 0; wcount[i] = 0; err_seen[i] = 0;
    end
  end

  always @(posedge clk) begin
    exp_cur[0]  <= exp_next[0];
    exp_cur[1]  <= exp_next[1];
    acc_last[0] <= pv3 && !srst3;
    acc_last[1] <= pv5 && !srst5;
  end

  task automatic model_step(input int id, input logic v, input logic s,
                            input logic [7:0] px, input logic r);
    int pc, pr, k;
    logic emit, eof, err;
    win_t w;
    k = KP[id];
    exp_next[id] = 3'b000;
    if (r) begin
      mcol[id] = 0;
      mrow[id] = 0;
    end else if (v) begin
      pc  = s ? 0 : mcol[id];
      pr  = s ? 0 : mrow[id];
      err = s && (mcol[id] != 0 || mrow[id] != 0);
      img[id][pr][pc] = px;
      emit = (pr >= k - 1) && (pc >= k - 1);
      eof  = emit && (pc == WP[id] - 1) && (pr == HP[id] - 1);
      if (emit) begin
        w = '0;
        for (int rr = 0; rr < k; rr++)
          for (int cc = 0; cc < k; cc++)
            w[(rr*5+cc)*8 +: 8] = img[id][pr-k+1+rr][pc-k+1+cc];
        if (id == 0) q0.push_back(w); else q1.push_back(w);
      end
      exp_next[id] = {emit, eof, err};
      if (pc == WP[id] - 1) begin
        mcol[id] = 0;
        mrow[id] = (pr == HP[id] - 1) ? 0 : pr + 1;
      end else begin
        mcol[id] = pc + 1;
        mrow[id] = pr;
      end
    end
  endtask

  task automatic step(input int id, input logic v, input logic s,
                      input logic [7:0] px, input logic r);
    pv3 = 0; sop3 = 0; srst3 = 0;
    pv5 = 0; sop5 = 0; srst5 = 0;
    exp_next[1-id] = 3'b000;
    if (id == 0) begin
      pv3 = v; sop3 = s; px3 = px; srst3 = r;
    end else begin
      pv5 = v; sop5 = s; px5 = px; srst5 = r;
    end
    model_step(id, v, s, px, r);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input int id, input logic v, input logic e,
                             input logic s, input win_t w);
    win_t expw;
    bit   empty;
    checks++;
    if ({v, e, s} !== exp_cur[id]) begin
      errors++;
      $display("FAIL flags dut%0d t=%0t: got valid/eof/err=%b required %b",
               id, $time, {v, e, s}, exp_cur[id]);
    end
    if (v === 1'b1) begin
      checks++;
      if (!acc_last[id]) begin
        errors++;
        $display("FAIL valid_no_pixel dut%0d t=%0t: got valid=1 required 0", id, $time);
      end
      empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
      checks++;
      if (empty) begin
        errors++;
        $display("FAIL extra_window dut%0d t=%0t: got window, required none", id, $time);
      end else begin
        expw = (id == 0) ? q0.pop_front() : q1.pop_front();
        if (w !== expw) begin
          errors++;
          $display("FAIL window dut%0d #%0d t=%0t: got %h required %h",
                   id, wcount[id], $time, w, expw);
        end
      end
      if (wcount[id] < 16) begin
        cap_win[id][wcount[id]] = w;
        cap_eof[id][wcount[id]] = e;
      end
      wcount[id]++;
    end
    if (s === 1'b1) err_seen[id]++;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check_cycle(0, wv3, eof3, err3, flat3);
      check_cycle(1, wv5, eof5, err5, flat5);
    end
  end

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic send_frame(input int id, input logic [7:0] base, input bit gapped);
    for (int i = 0; i < WP[id] * HP[id]; i++) begin
      if (gapped)
        while ($urandom_range(1) == 1) step(id, 0, 0, 8'h00, 0);
      step(id, 1, (i == 0), base + 8'((i / WP[id]) * 16 + (i % WP[id])), 0);
    end
  endtask

  task automatic drain(input int id);
    for (int i = 0; i < 3; i++) step(id, 0, 0, 8'h00, 0);
    check_int($sformatf("queue_empty dut%0d", id), (id == 0) ? q0.size() : q1.size(), 0);
  endtask

  task automatic start_test(input int id);
    wcount[id]   = 0;
    err_seen[id] = 0;
  endtask

  spot_t spots[$];

  task automatic apply_spots(input int test);
    logic [7:0] got;
    foreach (spots[i]) begin
      if (spots[i].test == test) begin
        checks++;
        if (spots[i].widx >= wcount[spots[i].id]) begin
          errors++;
          $display("FAIL spot t%0d w%0d: got no window required window", test, spots[i].widx);
        end else if (spots[i].is_eof) begin
          got = {7'd0, cap_eof[spots[i].id][spots[i].widx]};
          if (got != spots[i].val) begin
            errors++;
            $display("FAIL spot_eof t%0d w%0d: got %0d required %0d",
                     test, spots[i].widx, got, spots[i].val);
          end
        end else begin
          got = cap_win[spots[i].id][spots[i].widx][(spots[i].r*5+spots[i].c)*8 +: 8];
          if (got != spots[i].val) begin
            errors++;
            $display("FAIL spot t%0d w%0d [%0d][%0d]: got %h required %h",
                     test, spots[i].widx, spots[i].r, spots[i].c, got, spots[i].val);
          end
        end
      end
    end
  endtask

  initial begin
    spots = '{
      '{1, 0, 0, 0, 0, 8'h00, 0}, '{1, 0, 0, 1, 1, 8'h11, 0}, '{1, 0, 0, 2, 2, 8'h22, 0},
      '{1, 0, 5, 2, 2, 8'h34, 0}, '{1, 0, 5, 0, 0, 8'h01, 1}, '{1, 0, 4, 0, 0, 8'h00, 1},
      '{2, 0, 0, 2, 2, 8'h22, 0}, '{2, 0, 5, 2, 2, 8'h34, 0}, '{2, 0, 5, 0, 0, 8'h01, 1},
      '{3, 0, 5, 0, 0, 8'h01, 1}, '{3, 0, 6, 0, 0, 8'h80, 0}, '{3, 0, 6, 2, 2, 8'hA2, 0},
      '{3, 0, 11, 2, 2, 8'hB4, 0}, '{3, 0, 11, 0, 0, 8'h01, 1},
      '{4, 0, 0, 0, 0, 8'h13, 0}, '{4, 0, 0, 1, 1, 8'h11, 0}, '{4, 0, 0, 2, 2, 8'h22, 0},
      '{5, 0, 0, 0, 0, 8'h00, 0}, '{5, 0, 0, 2, 2, 8'h22, 0}, '{5, 0, 5, 2, 2, 8'h34, 0},
      '{5, 0, 5, 0, 0, 8'h01, 1},
      '{6, 1, 0, 0, 0, 8'h00, 0}, '{6, 1, 0, 4, 4, 8'h44, 0}, '{6, 1, 7, 4, 4, 8'h57, 0},
      '{6, 1, 7, 0, 0, 8'h01, 1}
    };

    px3 = '0; pv3 = 0; sop3 = 0; srst3 = 1;
    px5 = '0; pv5 = 0; sop5 = 0; srst5 = 1;
    @(posedge clk);
    #1;
    checking = 1;

    // Reset state, then basic frame
    start_test(0);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 0);
    send_frame(0, 8'h00, 0);
    drain(0);
    check_int("basic_count", wcount[0], 6);
    apply_spots(1);

    // Gapped stream
    start_test(0);
    send_frame(0, 8'h00, 1);
    drain(0);
    check_int("gapped_count", wcount[0], 6);
    apply_spots(2);

    // Back-to-back frames
    start_test(0);
    send_frame(0, 8'h00, 0);
    send_frame(0, 8'h80, 0);
    drain(0);
    check_int("b2b_count", wcount[0], 12);
    check_int("b2b_sop_err", err_seen[0], 0);
    apply_spots(3);

    // Misplaced sop at pixel 0x13 (row 1, col 3)
    start_test(0);
    for (int i = 0; i < 8; i++)
      step(0, 1, (i == 0), 8'((i / 5) * 16 + (i % 5)), 0);
    step(0, 1, 1, 8'h13, 0);
    for (int i = 1; i < 20; i++)
      step(0, 1, 0, 8'((i / 5) * 16 + (i % 5)), 0);
    drain(0);
    check_int("resync_sop_err", err_seen[0], 1);
    check_int("resync_count", wcount[0], 6);
    apply_spots(4);

    // Mid-frame reset after pixel 0x21, then a clean frame
    start_test(0);
    for (int i = 0; i < 12; i++)
      step(0, 1, (i == 0), 8'((i / 5) * 16 + (i % 5)), 0);
    step(0, 1, 0, 8'h22, 1);
    step(0, 0, 0, 8'h00, 0);
    check_int("reset_count", wcount[0], 0);
    send_frame(0, 8'h00, 0);
    drain(0);
    check_int("after_reset_count", wcount[0], 6);
    apply_spots(5);

    // Parameter sweep: KERNEL_W=5 on an 8x6 image
    start_test(1);
    step(1, 0, 0, 8'h00, 1);
    step(1, 0, 0, 8'h00, 0);
    send_frame(1, 8'h00, 0);
    drain(1);
    check_int("sweep_count", wcount[1], 8);
    apply_spots(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
